// File: rtl/line_pkg.sv
// rtl/line_pkg.sv - shared line-table types and word unpack helper
package line_pkg;

   localparam int LINE_W      = 8;
   localparam int TABLE_DEPTH = 4;

   typedef struct packed {
      logic [LINE_W/2-1:0] x;
      logic [LINE_W/2-1:0] y;
   } line_t;

   // Upper half of the word is x, lower half is y
   function automatic line_t line_unpack(input logic [LINE_W-1:0] word);
      line_t l;
      l.x = word[LINE_W-1:LINE_W/2];
      l.y = word[LINE_W/2-1:0];
      return l;
   endfunction

endpackage

// File: rtl/line_table_loader_if.sv
// rtl/line_table_loader_if.sv - valid/ready word stream into the line-table loader
interface line_table_loader_if #(
   parameter int W = line_pkg::LINE_W
);
   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_data;

   modport master (output in_valid, output in_data, input in_ready);
   modport slave  (input in_valid, input in_data, output in_ready);
endinterface

// File: rtl/line_table_loader.sv
// rtl/line_table_loader.sv - fills a DEPTH-entry line table from a word stream
module line_table_loader
   import line_pkg::*;
#(
   parameter int W     = LINE_W,
   parameter int DEPTH = TABLE_DEPTH,
   localparam int AW   = $clog2(DEPTH),
   localparam int CW   = $clog2(DEPTH) + 1
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start,
   line_table_loader_if.slave   up,
   output line_t [DEPTH-1:0]    arr,
   output logic                 loaded,
   output logic                 busy,
   output logic [CW-1:0]        count
);

   typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

   localparam logic [CW-1:0] LAST = CW'(DEPTH - 1);

   state_t       state_q, state_d;
   logic         ready;
   logic         xfer;
   logic [W-1:0] word;

   assign word        = up.in_data;
   assign up.in_ready = ready;
   // start has priority: a word offered alongside start is consumed but dropped
   assign xfer        = up.in_valid && ready && !start;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   // Next state and state decodes; in_ready depends on state only
   always_comb begin
      state_d = state_q;
      ready   = 1'b0;
      busy    = 1'b0;
      case (state_q)
         IDLE: if (start) state_d = LOAD;
         LOAD: begin
            ready = 1'b1;
            busy  = 1'b1;
            if (xfer && count == LAST) state_d = DONE;
         end
         DONE: if (start) state_d = LOAD;
         default: state_d = IDLE;
      endcase
   end

   // Table writes, entry counter and loaded flag
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         arr    <= '0;
         count  <= '0;
         loaded <= 1'b0;
      end else begin
         case (state_q)
            IDLE: if (start) count <= '0;
            LOAD: begin
               if (start) begin
                  count <= '0;
               end else if (xfer) begin
                  arr[count[AW-1:0]] <= line_unpack(word);
                  count              <= count + 1'b1;
                  if (count == LAST) loaded <= 1'b1;
               end
            end
            DONE: begin
               if (start) begin
                  count  <= '0;
                  loaded <= 1'b0;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: doc/line_table_loader.md
Name: line_table_loader

Overview:
- Upstream feeder for the sel-indexed line-table selector.
- Accepts a stream of W-bit words over a valid/ready handshake.
- Unpacks each word into a line_t {x, y} entry and fills a DEPTH-entry packed table in index order.
- Signals when the table is complete; the selector consumes arr directly, treating it as meaningful only while loaded=1.

Parameters:
- W, 8, line width in bits; must be even; x and y are W/2 bits each.
- DEPTH, 4, number of table entries; must be a power of two, >= 2.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  single-cycle request to begin (or restart) a table load.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  loader can accept a word this cycle.
- in_data  input  W  word; [W-1:W/2] -> x, [W/2-1:0] -> y.
- arr  output  DEPTH x line_t (packed, DEPTH*W)  table contents; entry i is arr[i].
- loaded  output  1  table fully loaded and stable.
- busy  output  1  load in progress.
- count  output  $clog2(DEPTH)+1  entries written in the current load.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; arr all zero; count=0.
  - loaded=0, busy=0, in_ready=0.
  - Reset takes effect immediately, including mid-load; after release the block waits for start.
- State machine (one-hot or encoded; registered):
  - IDLE: in_ready=0. start -> LOAD, count<=0.
  - LOAD: busy=1, in_ready=1 (combinational decode of state only; never depends on in_valid).
    - Transfer = in_valid && in_ready.
    - On a transfer: arr[count] <= {in_data[W-1:W/2], in_data[W/2-1:0]}, count <= count+1.
    - Transfer with count==DEPTH-1: state -> DONE, count <= DEPTH.
  - DONE: loaded=1, busy=0, in_ready=0. start -> LOAD, count<=0, loaded drops next cycle.
- Latency:
  - A written entry is visible on arr the cycle after its handshake.
  - loaded rises exactly one cycle after the DEPTH-th handshake.
  - in_ready falls at that same edge, so no extra word is accepted.
- Entries not yet rewritten in a new load keep their previous values; consumers must gate on loaded.
- in_valid in IDLE or DONE: ignored, no state change, no arr write.
- Simultaneous start and transfer in LOAD: start wins.
  - The transfer is discarded (no arr write); count <= 0; state stays LOAD.
  - Upstream sees in_ready=1 that cycle, so the word is considered consumed and dropped. This is documented; upstream must not assert start and valid together.
- Gaps in in_valid: count holds, arr unchanged.
- count never exceeds DEPTH; no wrap within a load.
- All outputs are registered except in_ready and busy, which are pure state decodes.

Decomposition:
- Shared package line_pkg holds:
  - localparam LINE_W = 8 and TABLE_DEPTH = 4.
  - typedef struct packed { logic [LINE_W/2-1:0] x; logic [LINE_W/2-1:0] y; } line_t.
  - The same typedef is used by the selector, so both blocks share one definition.
- State enum (IDLE/LOAD/DONE) is local to the module.
- No sub-module; word-to-line_t unpack is a package function line_unpack.

Test Plan:
- Fill: reset, start, then send 0x43, 0x16, 0x8F, 0x66 back-to-back.
  - Required: arr[0]={4,3}, arr[1]={1,6}, arr[2]={8,F}, arr[3]={6,6}.
  - loaded=1 one cycle after the 4th handshake; in_ready=0 from then on; count=4.
- Bubbles: same data, in_valid low for 2 cycles between each word.
  - Required: count steps 0->1->2->3->4 only on handshake cycles; identical final arr; loaded timing tied to last handshake.
- Restart: start, send 0x11, 0x22, then start again, then 0xAA, 0xBB, 0xCC, 0xDD.
  - Required: arr = {A,A},{B,B},{C,C},{D,D}; loaded asserted once, after 0xDD.
- Start with transfer: in LOAD with count=2, assert start and in_valid with 0x55 in the same cycle.
  - Required: count=0 next cycle; no entry equals {5,5}; state remains LOAD.
- Async reset mid-load: assert rst asynchronously between clock edges after 2 words.
  - Required: arr all zero, count=0, busy=0, in_ready=0 before the next edge.
  - in_valid held high afterwards is ignored until start.
- Idle traffic: in_valid=1 with 0xFF in IDLE and in DONE.
  - Required: in_ready=0, arr unchanged, loaded unchanged.
